// File: rtl/multi_issue_fifo_pkg.sv
// Shared definitions for the multi-issue FIFO slice.
// Holds the default lane/depth parameters, the lane payload type and a
// helper for sizing the wrap-bit pointers.
package multi_issue_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PORT_NUM   = 4;
  localparam int DEF_DEPTH      = 16;

  typedef logic [DEF_DATA_WIDTH-1:0] fifo_lane_t;

  // Pointer carries one bit beyond the index so that full and empty differ.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_PTR_W = fifo_ptr_w(DEF_DEPTH);

endpackage

// File: rtl/multi_issue_fifo_count_one.sv
// count_one: counts set bits of a lane vector.
// With CONTINUOUS=1 only the unbroken run of ones starting at bit 0 is
// counted, so the result always describes an in-order lane prefix.
// Ports:
//   vec  in   WIDTH               lane flags, bit 0 is the oldest lane
//   num  out  $clog2(WIDTH+1)     number of counted lanes
module count_one #(
  parameter int WIDTH      = 4,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic [WIDTH-1:0]           vec,
  output logic [$clog2(WIDTH+1)-1:0] num
);

  localparam int NUM_W = $clog2(WIDTH + 1);

  logic run;

  always_comb begin
    num = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i] && (run || !CONTINUOUS)) begin
        num = num + NUM_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_issue_fifo.sv
// multi_issue_fifo: circular buffer accepting and releasing up to PORT_NUM
// entries per cycle, always as in-order lane prefixes.
// Ports:
//   clk         in   1                       clock
//   rst         in   1                       synchronous reset, active-high
//   flush       in   1                       discard all contents
//   push_data   in   PORT_NUM x DATA_WIDTH   lane payloads
//   push_valid  in   PORT_NUM                lane holds a new entry
//   push_ready  out  PORT_NUM                lanes accepted this cycle
//   pop_data    out  PORT_NUM x DATA_WIDTH   entries at head+0..head+PORT_NUM-1
//   pop_valid   out  PORT_NUM                lane holds a valid entry
//   pop_ready   in   PORT_NUM                consumer takes lane
//   count       out  $clog2(DEPTH)+1         occupied entries
//   full        out  1                       count == DEPTH
//   empty       out  1                       count == 0
module multi_issue_fifo
  import multi_issue_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PORT_NUM   = DEF_PORT_NUM,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [PORT_NUM-1:0][DATA_WIDTH-1:0] push_data,
  input  logic [PORT_NUM-1:0]                 push_valid,
  output logic [PORT_NUM-1:0]                 push_ready,
  output logic [PORT_NUM-1:0][DATA_WIDTH-1:0] pop_data,
  output logic [PORT_NUM-1:0]                 pop_valid,
  input  logic [PORT_NUM-1:0]                 pop_ready,
  output logic [fifo_ptr_w(DEPTH)-1:0]        count,
  output logic                                full,
  output logic                                empty
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(PORT_NUM + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] free;
  logic [PTR_W-1:0] req_push_w;
  logic [PTR_W-1:0] push_num;
  logic [CNT_W-1:0] req_push;
  logic [CNT_W-1:0] pop_num;
  logic [IDX_W-1:0] wr_idx [PORT_NUM];
  logic [IDX_W-1:0] rd_idx [PORT_NUM];
  logic             clear;

  assign clear = rst | flush;

  count_one #(
    .WIDTH      (PORT_NUM),
    .CONTINUOUS (1'b1)
  ) u_push_cnt (
    .vec (push_valid),
    .num (req_push)
  );

  count_one #(
    .WIDTH      (PORT_NUM),
    .CONTINUOUS (1'b1)
  ) u_pop_cnt (
    .vec (pop_valid & pop_ready),
    .num (pop_num)
  );

  assign count = wptr - rptr;
  assign full  = (count == PTR_W'(DEPTH));
  assign empty = (count == '0);

  // Space is judged on the registered count; entries popped this cycle
  // are not recycled until the next one.
  assign free       = PTR_W'(DEPTH) - count;
  assign req_push_w = PTR_W'(req_push);
  assign push_num   = (req_push_w > free) ? free : req_push_w;

  always_comb begin
    push_ready = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (!clear && (PTR_W'(i) < push_num)) begin
        push_ready[i] = 1'b1;
      end
    end
  end

  // Index wraps naturally by dropping the wrap bit of ptr+lane.
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      wr_idx[i] = IDX_W'(wptr + PTR_W'(i));
      rd_idx[i] = IDX_W'(rptr + PTR_W'(i));
    end
  end

  always_comb begin
    pop_valid = '0;
    pop_data  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      pop_valid[i] = (PTR_W'(i) < count);
      pop_data[i]  = mem[rd_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PORT_NUM; i++) begin
      if (push_ready[i]) begin
        mem[wr_idx[i]] <= push_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + push_num;
      rptr <= rptr + PTR_W'(pop_num);
    end
  end

endmodule

// File: tb/tb_multi_issue_fifo.sv
module tb_multi_issue_fifo;

  localparam int DW = 32;
  localparam int PN = 4;
  localparam int DP = 16;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [PN-1:0][DW-1:0] push_data;
  logic [PN-1:0]     push_valid;
  logic [PN-1:0]     push_ready;
  logic [PN-1:0][DW-1:0] pop_data;
  logic [PN-1:0]     pop_valid;
  logic [PN-1:0]     pop_ready;
  logic [4:0]        count;
  logic              full;
  logic              empty;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] sb [$];

  multi_issue_fifo #(.DATA_WIDTH(DW), .PORT_NUM(PN), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_data  (push_data),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every lane taken by the consumer must match the oldest
  // outstanding expected entry.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      logic run;
      run = 1'b1;
      for (int i = 0; i < PN; i++) begin
        if (run && pop_valid[i] && pop_ready[i]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected lane=%0d actual=%0h required=none", i, pop_data[i]);
          end else begin
            logic [DW-1:0] e;
            e = sb.pop_front();
            if (pop_data[i] !== e) begin
              failures++;
              $display("FAIL pop_data lane=%0d actual=%0h required=%0h", i, pop_data[i], e);
            end
          end
        end else begin
          run = 1'b0;
        end
      end
    end
  end

  // One cycle of stimulus. exp_* are hand-computed; negative means skip.
  task automatic step(input logic [3:0] pv, input logic [31:0] base, input logic [3:0] pr,
                      input logic fl, input logic r, input logic [3:0] exp_ready,
                      input int exp_count, input int exp_pvalid);
    push_valid = pv;
    pop_ready  = pr;
    flush      = fl;
    rst        = r;
    for (int i = 0; i < PN; i++) push_data[i] = base + 32'(i);
    for (int i = 0; i < PN; i++) if (exp_ready[i]) sb.push_back(base + 32'(i));
    @(negedge clk);
    chk("push_ready", 32'(push_ready), 32'(exp_ready));
    if (exp_count >= 0) begin
      chk("count", 32'(count), 32'(exp_count));
      chk("full", 32'(full), 32'(exp_count == DP));
      chk("empty", 32'(empty), 32'(exp_count == 0));
    end
    if (exp_pvalid >= 0) chk("pop_valid", 32'(pop_valid), 32'(exp_pvalid));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = '0; pop_ready = '0; push_data = '0;
    step(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b1, 4'b0000, -1, -1);

    // Idle after reset
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    push_valid = 4'b1111;
    #1;
    chk("rst_push_ready", 32'(push_ready), 32'hf);
    push_valid = 4'b0000;
    @(posedge clk); #1;

    // Gapped valid: only lanes before the hole are accepted
    step(4'b1011, 32'h100, 4'b0000, 1'b0, 1'b0, 4'b0011, 0, 4'b0000);
    step(4'b0000, 32'h0,   4'b0011, 1'b0, 1'b0, 4'b0000, 2, 4'b0011);

    // Fill, refuse when full, partial refill after a pop
    step(4'b1111, 32'h200, 4'b0000, 1'b0, 1'b0, 4'b1111, 0,  4'b0000);
    step(4'b1111, 32'h210, 4'b0000, 1'b0, 1'b0, 4'b1111, 4,  4'b1111);
    step(4'b1111, 32'h220, 4'b0000, 1'b0, 1'b0, 4'b1111, 8,  4'b1111);
    step(4'b1111, 32'h230, 4'b0000, 1'b0, 1'b0, 4'b1111, 12, 4'b1111);
    step(4'b1111, 32'h240, 4'b0000, 1'b0, 1'b0, 4'b0000, 16, 4'b1111);
    step(4'b0000, 32'h0,   4'b0011, 1'b0, 1'b0, 4'b0000, 16, 4'b1111);
    step(4'b1111, 32'h250, 4'b0000, 1'b0, 1'b0, 4'b0011, 14, 4'b1111);
    step(4'b0000, 32'h0,   4'b1111, 1'b0, 1'b0, 4'b0000, 16, 4'b1111);
    step(4'b0000, 32'h0,   4'b1111, 1'b0, 1'b0, 4'b0000, 12, 4'b1111);
    step(4'b0000, 32'h0,   4'b1111, 1'b0, 1'b0, 4'b0000, 8,  4'b1111);

    // Gapped ready: only lane0 taken, old lane1 moves to lane0
    step(4'b0000, 32'h0,   4'b1101, 1'b0, 1'b0, 4'b0000, 4,  4'b1111);
    chk("shift_lane0", pop_data[0], 32'h233);
    chk("shift_count", 32'(count), 32'd3);

    // Refill to full across the wrap, then simultaneous push+pop when full
    step(4'b1111, 32'h300, 4'b0000, 1'b0, 1'b0, 4'b1111, 3,  4'b0111);
    step(4'b1111, 32'h310, 4'b0000, 1'b0, 1'b0, 4'b1111, 7,  4'b1111);
    step(4'b1111, 32'h320, 4'b0000, 1'b0, 1'b0, 4'b1111, 11, 4'b1111);
    step(4'b0001, 32'h330, 4'b0000, 1'b0, 1'b0, 4'b0001, 15, 4'b1111);
    step(4'b1111, 32'h340, 4'b1111, 1'b0, 1'b0, 4'b0000, 16, 4'b1111);
    step(4'b1111, 32'h350, 4'b0000, 1'b0, 1'b0, 4'b1111, 12, 4'b1111);
    step(4'b0000, 32'h0,   4'b1111, 1'b0, 1'b0, 4'b0000, 16, 4'b1111);
    step(4'b0000, 32'h0,   4'b1111, 1'b0, 1'b0, 4'b0000, 12, 4'b1111);
    step(4'b0000, 32'h0,   4'b1111, 1'b0, 1'b0, 4'b0000, 8,  4'b1111);
    step(4'b0000, 32'h0,   4'b1111, 1'b0, 1'b0, 4'b0000, 4,  4'b1111);
    step(4'b0000, 32'h0,   4'b0000, 1'b0, 1'b0, 4'b0000, 0,  4'b0000);

    // Flush with pending push and pop
    step(4'b1111, 32'h400, 4'b0000, 1'b0, 1'b0, 4'b1111, 0, 4'b0000);
    step(4'b0111, 32'h410, 4'b0000, 1'b0, 1'b0, 4'b0111, 4, 4'b1111);
    step(4'b1111, 32'h420, 4'b1111, 1'b1, 1'b0, 4'b0000, 7, 4'b1111);
    step(4'b0000, 32'h0,   4'b0000, 1'b0, 1'b0, 4'b0000, 0, 4'b0000);

    // Reset mid-operation behaves the same
    step(4'b1111, 32'h500, 4'b0000, 1'b0, 1'b0, 4'b1111, 0, 4'b0000);
    step(4'b0111, 32'h510, 4'b0000, 1'b0, 1'b0, 4'b0111, 4, 4'b1111);
    step(4'b1111, 32'h520, 4'b1111, 1'b0, 1'b1, 4'b0000, 7, 4'b1111);
    step(4'b0000, 32'h0,   4'b0000, 1'b0, 1'b0, 4'b0000, 0, 4'b0000);

    // Fresh traffic after the clear
    step(4'b0011, 32'h600, 4'b0000, 1'b0, 1'b0, 4'b0011, 0, 4'b0000);
    step(4'b0000, 32'h0,   4'b0011, 1'b0, 1'b0, 4'b0000, 2, 4'b0011);
    step(4'b0000, 32'h0,   4'b0000, 1'b0, 1'b0, 4'b0000, 0, 4'b0000);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
